// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the APB side of the AHB-to-APB bridge:
// completer FSM states, register-bank constants and error classification.
package ahb2apb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE,
        ERR_READ_ONLY
    } apb_err_t;

    localparam logic [31:0] ID_VALUE    = 32'hA2B0_0001;
    localparam int unsigned REG_IDX_LSB = 2;
    localparam int unsigned WAIT_CNT_W  = 4;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter for APB wait-state insertion; saturates at zero.
module apb_wait_counter
    import ahb2apb_pkg::*;
#(
    parameter int unsigned WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB3 completer with a small register bank (register 0 = read-only ID),
// programmable wait states and pslverr on misaligned/out-of-range/RO accesses.
module apb_regbank_slave
    import ahb2apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int unsigned IDX_W = ADDR_WIDTH - REG_IDX_LSB;
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]      NUM_IDX   = IDX_W'(NUM_REGS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    apb_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  load, dec, commit, done_nxt;
    logic [WAIT_CNT_W-1:0] count;
    logic                  zero;

    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  eff_write;
    logic [IDX_W-1:0]      idx;
    apb_err_t              err;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    apb_wait_counter #(
        .WIDTH(WAIT_CNT_W)
    ) u_wait_counter (
        .clk      (hclk),
        .rst      (hreset),
        .load     (load),
        .load_val (WAIT_LOAD),
        .dec      (dec),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (psel && !penable) state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (!psel) begin
                    state_nxt = ST_IDLE;
                end else if (penable && zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // pready is registered, so completion is predicted one cycle ahead:
    // at setup when there are no wait states, else on the last wait cycle.
    always_comb begin
        load     = 1'b0;
        dec      = 1'b0;
        commit   = 1'b0;
        done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                load     = psel && !penable;
                done_nxt = load && (WAIT_STATES == 0);
            end
            ST_ACCESS: begin
                dec      = psel && penable && !zero;
                commit   = psel && penable && zero;
                done_nxt = dec && (count == CNT_ONE);
            end
            default: ;
        endcase
    end

    // Decode the live bus during setup so a zero-wait response can be formed
    // in the same edge that latches the request.
    assign eff_addr  = load ? paddr  : addr_q;
    assign eff_write = load ? pwrite : write_q;
    assign idx       = eff_addr[ADDR_WIDTH-1:REG_IDX_LSB];

    always_comb begin
        err = ERR_NONE;
        if (eff_addr[REG_IDX_LSB-1:0] != '0) begin
            err = ERR_MISALIGN;
        end else if (idx >= NUM_IDX) begin
            err = ERR_RANGE;
        end else if (eff_write && (idx == '0)) begin
            err = ERR_READ_ONLY;
        end
    end

    always_comb begin
        rd_val = '0;
        if (idx == '0) begin
            rd_val = DATA_WIDTH'(ID_VALUE);
        end else if (idx < NUM_IDX) begin
            rd_val = regs[idx[SEL_W-1:0]];
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (load) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
            pready  <= done_nxt;
            pslverr <= done_nxt && (err != ERR_NONE);
            prdata  <= (done_nxt && !eff_write && (err == ERR_NONE)) ? rd_val : '0;
            if (commit && write_q && (err == ERR_NONE)) begin
                regs[idx[SEL_W-1:0]] <= wdata_q;
            end
        end
    end

endmodule
